uart_bridge_reg_block: RTL and testbench

//  AXI4-Lite slave register file for the UART-AXI4 bridge system. It sits on the bridge's AXI master

---
 rtl/uart_bridge_reg_block_if.sv | 41 ++++
 rtl/uart_bridge_reg_block.sv | 156 +++++++++++++++
 tb/tb_uart_bridge_reg_block.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bridge_reg_block_if.sv
// AXI4-Lite bus bundle shared by the UART bridge master and its register-file slave.
interface axi4_lite_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/uart_bridge_reg_block.sv
// AXI4-Lite register file exposing UART bridge configuration, status counters and scratch registers.
module uart_bridge_reg_block #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rst,
  axi4_lite_if.slave       axi,
  output logic             bridge_reset_stats,
  output logic [7:0]       baud_div_config,
  output logic [7:0]       timeout_config,
  output logic [3:0]       debug_mode,
  input  logic [7:0]       error_code,
  input  logic [15:0]      tx_count,
  input  logic [15:0]      rx_count,
  input  logic [7:0]       fifo_status
);

  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;
  localparam logic [DATA_WIDTH-1:0] VERSION     = 32'h0001_0000;

  logic                    aw_done;
  logic                    w_done;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic                    bvalid_q;
  logic [1:0]              bresp_q;
  logic                    rvalid_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [15:0]             cfg_q;
  logic [3:0]              dbg_q;
  logic [DATA_WIDTH-1:0]   test_q [4];
  logic                    stats_pulse_q;

  logic                    wr_commit;
  logic                    wr_ok;
  logic [3:0]              wr_idx;
  logic                    ar_hs;
  logic                    rd_ok;
  logic [3:0]              rd_idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:12] == BASE_ADDR[ADDR_WIDTH-1:12]) &&
           (a[1:0] == 2'b00) && (a[11:0] <= 12'h02C);
  endfunction

  // Ready flags are gated by rst so they read 0 throughout reset.
  assign axi.awready = rst && !aw_done && !bvalid_q;
  assign axi.wready  = rst && !w_done  && !bvalid_q;
  assign axi.arready = rst && !rvalid_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_q;

  assign bridge_reset_stats = stats_pulse_q;
  assign baud_div_config    = cfg_q[7:0];
  assign timeout_config     = cfg_q[15:8];
  assign debug_mode         = dbg_q;

  assign wr_commit = aw_done && w_done && !bvalid_q;
  assign wr_ok     = addr_ok(aw_addr_q);
  assign wr_idx    = aw_addr_q[5:2];
  assign ar_hs     = axi.arvalid && axi.arready;
  assign rd_ok     = addr_ok(axi.araddr);
  assign rd_idx    = axi.araddr[5:2];

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      4'h1: rd_word[7:0]  = error_code;
      4'h2: rd_word[15:0] = cfg_q;
      4'h3: rd_word[3:0]  = dbg_q;
      4'h4: rd_word[15:0] = tx_count;
      4'h5: rd_word[15:0] = rx_count;
      4'h6: rd_word[7:0]  = fifo_status;
      4'h7: rd_word       = VERSION;
      4'h8, 4'h9, 4'hA, 4'hB: rd_word = test_q[rd_idx[1:0]];
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      rvalid_q      <= 1'b0;
      rresp_q       <= RESP_OKAY;
      rdata_q       <= '0;
      cfg_q         <= '0;
      dbg_q         <= '0;
      stats_pulse_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) test_q[i] <= '0;
    end else begin
      stats_pulse_q <= 1'b0;

      if (axi.awvalid && axi.awready) begin
        aw_done   <= 1'b1;
        aw_addr_q <= axi.awaddr;
      end
      if (axi.wvalid && axi.wready) begin
        w_done   <= 1'b1;
        w_data_q <= axi.wdata;
        w_strb_q <= axi.wstrb;
      end

      // Register update and response are issued together; the stats pulse coincides with the first B cycle.
      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          case (wr_idx)
            4'h0: stats_pulse_q <= w_strb_q[0] && w_data_q[0];
            4'h2: begin
              if (w_strb_q[0]) cfg_q[7:0]  <= w_data_q[7:0];
              if (w_strb_q[1]) cfg_q[15:8] <= w_data_q[15:8];
            end
            4'h3: if (w_strb_q[0]) dbg_q <= w_data_q[3:0];
            4'h8, 4'h9, 4'hA, 4'hB: begin
              for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
                if (w_strb_q[b]) test_q[wr_idx[1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
              end
            end
            default: ;
          endcase
        end
      end

      if (bvalid_q && axi.bready) begin
        bvalid_q <= 1'b0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_ok ? rd_word : '0;
        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_bridge_reg_block.sv
// Directed self-checking bench for the UART bridge AXI4-Lite register file.
module tb_uart_bridge_reg_block;
  logic        clk;
  logic        rst;
  logic        bridge_reset_stats;
  logic [7:0]  baud_div_config;
  logic [7:0]  timeout_config;
  logic [3:0]  debug_mode;
  logic [7:0]  error_code;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic [7:0]  fifo_status;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int pulse_b_cnt = 0;

  axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  uart_bridge_reg_block #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_1000)) dut (
    .clk(clk), .rst(rst), .axi(axi),
    .bridge_reset_stats(bridge_reset_stats), .baud_div_config(baud_div_config),
    .timeout_config(timeout_config), .debug_mode(debug_mode),
    .error_code(error_code), .tx_count(tx_count), .rx_count(rx_count), .fifo_status(fifo_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bridge_reset_stats === 1'b1) begin
      pulse_cnt++;
      if (axi.bvalid === 1'b1) pulse_b_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_ok, w_ok, aw_hs, w_hs, got;
    int n;
    axi.awaddr = a; axi.awprot = 3'b000; axi.awvalid = 1'b1;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1; axi.bready = 1'b1;
    aw_ok = 0; w_ok = 0; got = 0; n = 0; resp = 2'bxx;
    while (!(aw_ok && w_ok) && n < 50) begin
      @(negedge clk);
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(posedge clk); #1;
      if (aw_hs) begin axi.awvalid = 1'b0; aw_ok = 1; end
      if (w_hs)  begin axi.wvalid  = 1'b0; w_ok  = 1; end
      n++;
    end
    while (!got && n < 50) begin
      @(negedge clk);
      if (axi.bvalid) begin resp = axi.bresp; got = 1; end
      @(posedge clk); #1;
      n++;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL write_timeout addr=%h got no bvalid, required bvalid within 50 cycles", a); end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_ok, ar_hs, got;
    int n;
    axi.araddr = a; axi.arprot = 3'b000; axi.arvalid = 1'b1; axi.rready = 1'b1;
    ar_ok = 0; got = 0; n = 0; d = 'x; resp = 2'bxx;
    while (!ar_ok && n < 50) begin
      @(negedge clk);
      ar_hs = axi.arvalid && axi.arready;
      @(posedge clk); #1;
      if (ar_hs) begin axi.arvalid = 1'b0; ar_ok = 1; end
      n++;
    end
    while (!got && n < 50) begin
      @(negedge clk);
      if (axi.rvalid) begin d = axi.rdata; resp = axi.rresp; got = 1; end
      @(posedge clk); #1;
      n++;
    end
    axi.arvalid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL read_timeout addr=%h got no rvalid, required rvalid within 50 cycles", a); end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, bridge_reset_stats} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshake got aw/w/ar/b/r/pulse=%b required 000000",
               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, bridge_reset_stats});
    end
    checks++;
    if ({baud_div_config, timeout_config, debug_mode, axi.rdata, axi.bresp, axi.rresp} !== '0) begin
      errors++;
      $display("FAIL reset_regs got baud=%h tmo=%h dbg=%h rdata=%h bresp=%b rresp=%b required all 0",
               baud_div_config, timeout_config, debug_mode, axi.rdata, axi.bresp, axi.rresp);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    axi_read(32'h0000_1008, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL reset_config got %h/%b required 00000000/00", d, r); end
    axi_read(32'h0000_100C, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL reset_debug got %h/%b required 00000000/00", d, r); end
    axi_read(32'h0000_1020, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL reset_test0 got %h/%b required 00000000/00", d, r); end
    axi_read(32'h0000_101C, d, r);
    checks++; if (d !== 32'h0001_0000 || r !== 2'b00) begin errors++; $display("FAIL version got %h/%b required 00010000/00", d, r); end
  endtask

  task automatic test_scratch();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h0000_1020, 32'hCAFE_BABE, 4'hF, r);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL test0_bresp got %b required 00", r); end
    axi_read(32'h0000_1020, d, r);
    checks++; if (d !== 32'hCAFE_BABE || r !== 2'b00) begin errors++; $display("FAIL test0_read got %h/%b required cafebabe/00", d, r); end
    axi_write(32'h0000_102C, 32'h1122_3344, 4'hF, r);
    axi_write(32'h0000_102C, 32'hAABB_CCDD, 4'b1010, r);
    axi_read(32'h0000_102C, d, r);
    checks++; if (d !== 32'hAA22_CC44) begin errors++; $display("FAIL test3_strb got %h required aa22cc44", d); end
  endtask

  task automatic test_config();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h0000_1008, 32'h0000_3412, 4'hF, r);
    checks++;
    if (baud_div_config !== 8'h12 || timeout_config !== 8'h34) begin
      errors++; $display("FAIL config_outputs got baud=%h tmo=%h required 12/34", baud_div_config, timeout_config);
    end
    axi_write(32'h0000_1008, 32'h0000_00FF, 4'h1, r);
    axi_read(32'h0000_1008, d, r);
    checks++; if (d !== 32'h0000_34FF) begin errors++; $display("FAIL config_strb got %h required 000034ff", d); end
    axi_write(32'h0000_1008, 32'hFFFF_5678, 4'hF, r);
    axi_read(32'h0000_1008, d, r);
    checks++; if (d !== 32'h0000_5678) begin errors++; $display("FAIL config_upper got %h required 00005678", d); end
    axi_write(32'h0000_100C, 32'hFFFF_FFF9, 4'hF, r);
    axi_read(32'h0000_100C, d, r);
    checks++;
    if (d !== 32'h0000_0009 || debug_mode !== 4'h9) begin
      errors++; $display("FAIL debug got %h/%h required 00000009/9", d, debug_mode);
    end
  endtask

  task automatic test_status();
    logic [31:0] d; logic [1:0] r;
    tx_count = 16'h1234; error_code = 8'h5A; rx_count = 16'hBEEF; fifo_status = 8'hA5;
    axi_read(32'h0000_1010, d, r);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL tx_count got %h required 00001234", d); end
    axi_read(32'h0000_1004, d, r);
    checks++; if (d !== 32'h0000_005A) begin errors++; $display("FAIL status got %h required 0000005a", d); end
    axi_read(32'h0000_1014, d, r);
    checks++; if (d !== 32'h0000_BEEF) begin errors++; $display("FAIL rx_count got %h required 0000beef", d); end
    axi_read(32'h0000_1018, d, r);
    checks++; if (d !== 32'h0000_00A5) begin errors++; $display("FAIL fifo_status got %h required 000000a5", d); end
    axi_write(32'h0000_1004, 32'hFFFF_FFFF, 4'hF, r);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL ro_write_bresp got %b required 00", r); end
    axi_read(32'h0000_1004, d, r);
    checks++; if (d !== 32'h0000_005A) begin errors++; $display("FAIL ro_write_effect got %h required 0000005a", d); end
  endtask

  task automatic test_reset_stats();
    logic [31:0] d; logic [1:0] r;
    int p0, pb0;
    p0 = pulse_cnt; pb0 = pulse_b_cnt;
    axi_write(32'h0000_1000, 32'h0000_0001, 4'hF, r);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (pulse_cnt - p0 !== 1 || pulse_b_cnt - pb0 !== 1) begin
      errors++; $display("FAIL stats_pulse got %0d cycles (%0d with bvalid) required 1 (1)", pulse_cnt - p0, pulse_b_cnt - pb0);
    end
    axi_read(32'h0000_1000, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL control_read got %h/%b required 00000000/00", d, r); end
    p0 = pulse_cnt;
    axi_write(32'h0000_1000, 32'h0000_0001, 4'hE, r);
    axi_write(32'h0000_1000, 32'h0000_0000, 4'hF, r);
    repeat (3) @(posedge clk); #1;
    checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL stats_no_pulse got %0d cycles required 0", pulse_cnt - p0); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r;
    int bad;
    axi.bready = 1'b0;
    axi.wdata = 32'h5555_AAAA; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(negedge clk);
    checks++; if (axi.wready !== 1'b1) begin errors++; $display("FAIL w_first_ready got %b required 1", axi.wready); end
    @(posedge clk); #1; axi.wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi.wready, axi.awready, axi.bvalid} !== 3'b010) begin
      errors++; $display("FAIL w_latched got w/aw/b=%b required 010", {axi.wready, axi.awready, axi.bvalid});
    end
    @(posedge clk); #1;
    axi.awaddr = 32'h0000_1024; axi.awprot = 3'b000; axi.awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; axi.awvalid = 1'b0;
    @(posedge clk); #1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00 || axi.awready !== 1'b0 || axi.wready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b_hold got %0d bad cycles required 0", bad); end
    @(posedge clk); #1; axi.bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL b_release got bvalid=%b required 0", axi.bvalid); end
    axi_read(32'h0000_1024, d, r);
    checks++; if (d !== 32'h5555_AAAA) begin errors++; $display("FAIL test1_read got %h required 5555aaaa", d); end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r;
    axi_read(32'h0000_1030, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL rd_oob got %h/%b required 00000000/10", d, r); end
    axi_read(32'h0000_1022, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL rd_unaligned got %h/%b required 00000000/10", d, r); end
    axi_read(32'h0000_2020, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL rd_window got %h/%b required 00000000/10", d, r); end
    axi_write(32'h0000_1030, 32'h1234_5678, 4'hF, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL wr_oob got %b required 10", r); end
    axi_write(32'h0000_1026, 32'h0, 4'hF, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL wr_unaligned got %b required 10", r); end
    axi_write(32'h0000_0024, 32'h0, 4'hF, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL wr_window got %b required 10", r); end
    axi_read(32'h0000_1024, d, r);
    checks++; if (d !== 32'h5555_AAAA) begin errors++; $display("FAIL slverr_no_effect got %h required 5555aaaa", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h0000_1028, 32'h1111_1111, 4'hF, r);
    axi.bready = 1'b1; axi.rready = 1'b1;
    axi.awaddr = 32'h0000_1028; axi.awvalid = 1'b1;
    axi.wdata = 32'h2222_2222; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    axi.araddr = 32'h0000_1028; axi.arvalid = 1'b1;
    @(negedge clk);
    checks++; if (axi.arready !== 1'b1) begin errors++; $display("FAIL same_cycle_arready got %b required 1", axi.arready); end
    @(posedge clk); #1; axi.arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h1111_1111 || axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
      errors++; $display("FAIL same_cycle_rw got rvalid=%b rdata=%h bvalid=%b bresp=%b required 1/11111111/1/00",
                         axi.rvalid, axi.rdata, axi.bvalid, axi.bresp);
    end
    @(posedge clk); #1;
    axi_read(32'h0000_1028, d, r);
    checks++; if (d !== 32'h2222_2222) begin errors++; $display("FAIL after_rw got %h required 22222222", d); end
  endtask

  initial begin
    rst = 1'b0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    error_code = '0; tx_count = '0; rx_count = '0; fifo_status = '0;
    test_reset();
    test_scratch();
    test_config();
    test_status();
    test_reset_stats();
    test_w_before_aw();
    test_slverr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
